// File: rtl/seg_display_capture.sv
// seg_display_capture: receive side of the 8-digit multiplexed seven-segment
// interface. Samples the scanned atog / seg_cs lines, decodes each digit back
// to a hex nibble and reports each completed 32-bit word with a frame strobe.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-low reset
//   atog[7:0]    segments, active-low; bit0=a .. bit6=g, bit7=dp
//   seg_cs[7:0]  digit selects, active-low; seg_cs[i]=0 selects digit i
//   value[31:0]  last completed decoded word (digit i -> value[4i+3:4i])
//   frame_valid  one-cycle pulse when value updates
//   frame_err    last completed frame contained an undecodable pattern
//   stale        no frame completed within STALE_CYCLES
//   dp[7:0]      captured decimal points (only when SEG_CAP_DP_EN is defined)
//
// Parameters:
//   SETTLE        matching consecutive samples before a digit is taken (1..15)
//   STALE_CYCLES  cycles without a completed frame before stale asserts (>= 2)
//
// Optional feature macro: SEG_CAP_DP_EN adds the dp port and captures the
// decimal points; without it atog[7] only takes part in the settle compare.

module seg_display_capture #(
    parameter int SETTLE       = 3,
    parameter int STALE_CYCLES = 65536
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  atog,
    input  logic [7:0]  seg_cs,
    output logic [31:0] value,
    output logic        frame_valid,
    output logic        frame_err,
`ifdef SEG_CAP_DP_EN
    output logic        stale,
    output logic [7:0]  dp
`else
    output logic        stale
`endif
);

    localparam int            SW         = $clog2(STALE_CYCLES + 1);
    localparam logic [3:0]    SETTLE_MAX = 4'(SETTLE);
    localparam logic [SW-1:0] STALE_MAX  = SW'(STALE_CYCLES);

    // Input sampling stage and its one-cycle-delayed copy for the
    // stability compare.
    logic [7:0]    atog_q;
    logic [7:0]    cs_q;
    logic [7:0]    atog_p;
    logic [7:0]    cs_p;

    logic [3:0]    settle_cnt;
    logic          dwell_done;
    logic [7:0]    seen;
    logic [31:0]   shadow;
    logic          sticky;
    logic [SW-1:0] stale_cnt;

    logic          same;
    logic [3:0]    settle_nxt;
    logic [7:0]    sel;
    logic          onehot;
    logic [2:0]    idx;
    logic          capture;
    logic [3:0]    dec_nib;
    logic          dec_bad;
    logic [7:0]    seen_nxt;
    logic [31:0]   shadow_nxt;
    logic          sticky_nxt;
    logic          done;
    logic [SW-1:0] stale_inc;
    logic          dwell_nxt;

    // Returns {bad, nibble} for an active-high gfedcba pattern.
    function automatic logic [4:0] decode(input logic [6:0] seg);
        logic [4:0] r;
        case (seg)
            7'h3F:   r = 5'h00;
            7'h06:   r = 5'h01;
            7'h5B:   r = 5'h02;
            7'h4F:   r = 5'h03;
            7'h66:   r = 5'h04;
            7'h6D:   r = 5'h05;
            7'h7D:   r = 5'h06;
            7'h07:   r = 5'h07;
            7'h7F:   r = 5'h08;
            7'h6F:   r = 5'h09;
            7'h77:   r = 5'h0A;
            7'h7C:   r = 5'h0B;
            7'h39:   r = 5'h0C;
            7'h5E:   r = 5'h0D;
            7'h79:   r = 5'h0E;
            7'h71:   r = 5'h0F;
            default: r = 5'h10;
        endcase
        return r;
    endfunction

    always_comb begin
        same       = ({cs_q, atog_q} == {cs_p, atog_p});
        settle_nxt = 4'd0;
        if (same) begin
            settle_nxt = (settle_cnt == SETTLE_MAX) ? settle_cnt
                                                    : settle_cnt + 4'd1;
        end

        sel    = ~cs_q;
        onehot = (sel != 8'h00) && ((sel & (sel - 8'd1)) == 8'h00);
        idx    = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (sel[i]) begin
                idx = 3'(i);
            end
        end

        // The counter reaching SETTLE on this edge is the capture point;
        // dwell_done keeps a long dwell from capturing again.
        capture = same && (settle_nxt == SETTLE_MAX) && !dwell_done && onehot;

        {dec_bad, dec_nib} = decode(~atog_q[6:0]);

        seen_nxt   = seen;
        shadow_nxt = shadow;
        sticky_nxt = sticky;
        if (capture) begin
            seen_nxt[idx]                   = 1'b1;
            shadow_nxt[{idx, 2'b00} +: 4] = dec_bad ? 4'h0 : dec_nib;
            sticky_nxt                      = sticky | dec_bad;
        end
        done = (seen_nxt == 8'hFF);

        dwell_nxt = 1'b0;
        if (same) begin
            dwell_nxt = dwell_done | capture;
        end

        stale_inc = (stale_cnt == STALE_MAX) ? stale_cnt
                                             : stale_cnt + SW'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            atog_q <= 8'hFF;
            cs_q   <= 8'hFF;
            atog_p <= 8'hFF;
            cs_p   <= 8'hFF;
        end else begin
            atog_q <= atog;
            cs_q   <= seg_cs;
            atog_p <= atog_q;
            cs_p   <= cs_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            settle_cnt <= 4'd0;
            dwell_done <= 1'b0;
        end else begin
            settle_cnt <= settle_nxt;
            dwell_done <= dwell_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seen        <= 8'h00;
            shadow      <= 32'h0;
            sticky      <= 1'b0;
            value       <= 32'h0;
            frame_err   <= 1'b0;
            frame_valid <= 1'b0;
        end else begin
            shadow      <= shadow_nxt;
            frame_valid <= done;
            if (done) begin
                value     <= shadow_nxt;
                frame_err <= sticky_nxt;
                seen      <= 8'h00;
                sticky    <= 1'b0;
            end else begin
                seen   <= seen_nxt;
                sticky <= sticky_nxt;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stale_cnt <= '0;
            stale     <= 1'b0;
        end else if (done) begin
            stale_cnt <= '0;
            stale     <= 1'b0;
        end else begin
            stale_cnt <= stale_inc;
            stale     <= (stale_inc == STALE_MAX);
        end
    end

`ifdef SEG_CAP_DP_EN
    logic [7:0] dp_shadow;
    logic [7:0] dp_nxt;

    always_comb begin
        dp_nxt = dp_shadow;
        if (capture) begin
            dp_nxt[idx] = ~atog_q[7];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dp_shadow <= 8'h00;
            dp        <= 8'h00;
        end else begin
            dp_shadow <= dp_nxt;
            if (done) begin
                dp <= dp_nxt;
            end
        end
    end
`endif

endmodule

// File: tb/tb_seg_display_capture.sv
// tb_seg_display_capture: scoreboard bench for seg_display_capture.
// Frames are queued when scanned and compared when frame_valid pulses.

module tb_seg_display_capture;

    localparam int SETTLE = 3;
    localparam int STALE  = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  atog;
    logic [7:0]  seg_cs;
    logic [31:0] value;
    logic        frame_valid;
    logic        frame_err;
    logic        stale;
`ifdef SEG_CAP_DP_EN
    logic [7:0]  dp;
`endif

    seg_display_capture #(
        .SETTLE       (SETTLE),
        .STALE_CYCLES (STALE)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .atog        (atog),
        .seg_cs      (seg_cs),
        .value       (value),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
`ifdef SEG_CAP_DP_EN
        .stale       (stale),
        .dp          (dp)
`else
        .stale       (stale)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int frames = 0;
    int cyc = 0;
    int last_fv_cyc = 0;
    logic [32:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Active-low atog pattern for a hex digit, dp off.
    function automatic logic [7:0] enc(input logic [3:0] n);
        case (n)
            4'h0: return 8'hC0;
            4'h1: return 8'hF9;
            4'h2: return 8'hA4;
            4'h3: return 8'hB0;
            4'h4: return 8'h99;
            4'h5: return 8'h92;
            4'h6: return 8'h82;
            4'h7: return 8'hF8;
            4'h8: return 8'h80;
            4'h9: return 8'h90;
            4'hA: return 8'h88;
            4'hB: return 8'h83;
            4'hC: return 8'hC6;
            4'hD: return 8'hA1;
            4'hE: return 8'h86;
            default: return 8'h8E;
        endcase
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (reset === 1'b1 && frame_valid === 1'b1) begin
            logic [32:0] e;
            frames++;
            last_fv_cyc = cyc;
            check("stale_at_fv", {63'd0, stale}, 64'd0);
            if (exp_q.size() == 0) begin
                check("unexp_frame", 64'(value), 64'hDEAD);
            end else begin
                e = exp_q.pop_front();
                check("value", 64'(value), 64'(e[31:0]));
                check("frame_err", {63'd0, frame_err}, {63'd0, e[32]});
`ifdef SEG_CAP_DP_EN
                check("dp", 64'(dp), 64'd0);
`endif
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            seg_cs = 8'hFF;
            atog   = 8'hFF;
        end
    endtask

    // Scan digits first..last of word; digits flagged in badm get blank atog.
    task automatic scan(input logic [31:0] word, input int dwell,
                        input bit glitch, input logic [7:0] badm,
                        input bit expect_frame, input int first,
                        input int last);
        logic [31:0] ew;
        ew = word;
        for (int i = 0; i < 8; i++) begin
            if (badm[i]) ew[4*i +: 4] = 4'h0;
        end
        if (expect_frame) exp_q.push_back({|badm, ew});
        for (int i = first; i <= last; i++) begin
            if (glitch) begin
                @(negedge clk);
                seg_cs = 8'hFF;
                atog   = 8'hC0;
                @(negedge clk);
                seg_cs = 8'hFC;
                atog   = 8'hA4;
            end
            @(negedge clk);
            seg_cs = ~(8'd1 << i);
            atog   = badm[i] ? 8'hFF : enc(word[4*i +: 4]);
            repeat (dwell - 1) @(negedge clk);
        end
        idle(6);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_value", 64'(value), 64'd0);
        check("rst_fv", {63'd0, frame_valid}, 64'd0);
        check("rst_err", {63'd0, frame_err}, 64'd0);
        check("rst_stale", {63'd0, stale}, 64'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        int f0;
        int t0;
        bit got;
        reset  = 1'b0;
        atog   = 8'hFF;
        seg_cs = 8'hFF;
        repeat (3) @(negedge clk);
        check("init_value", 64'(value), 64'd0);
        check("init_stale", {63'd0, stale}, 64'd0);
        reset = 1'b1;

        scan(32'h0000FCD2, 16, 1'b0, 8'h00, 1'b1, 0, 7);

        do_reset();
        f0 = frames;
        scan(32'h0000FCD2, SETTLE - 1, 1'b0, 8'h00, 1'b0, 0, 7);
        idle(10);
        check("short_nofrm", 64'(frames), 64'(f0));
        check("short_value", 64'(value), 64'd0);

        scan(32'h0000FCD2, 16, 1'b0, 8'h20, 1'b1, 0, 7);
        scan(32'h0000FCD2, 16, 1'b0, 8'h00, 1'b1, 0, 7);
        scan(32'h0000FCD2, 16, 1'b1, 8'h00, 1'b1, 0, 7);

        got = 1'b0;
        for (int k = 0; k < 200 && !got; k++) begin
            @(posedge clk);
            #1;
            if (stale) begin
                got = 1'b1;
                t0  = cyc;
            end
        end
        check("stale_seen", {63'd0, got}, 64'd1);
        if (got) check("stale_lat", 64'(t0 - last_fv_cyc), 64'(STALE));
        scan(32'h13579BDF, 16, 1'b0, 8'h00, 1'b1, 0, 7);
        check("stale_clr", {63'd0, stale}, 64'd0);

        for (int r = 0; r < 3; r++) begin
            scan($urandom, 8 + (r * 3), r[0], 8'h00, 1'b1, 0, 7);
        end

        scan(32'h87654321, 16, 1'b0, 8'h00, 1'b0, 0, 4);
        do_reset();
        f0 = frames;
        scan(32'h87654321, 16, 1'b0, 8'h00, 1'b0, 5, 7);
        idle(10);
        check("rst_partial", 64'(frames), 64'(f0));
        check("rst_hold", 64'(value), 64'd0);
        scan(32'h87654321, 16, 1'b0, 8'h00, 1'b1, 0, 7);

        idle(20);
        check("q_left", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
